// File: rtl/axi2mem_tcdm_pkg.sv
// Shared types and constants for the axi2mem TCDM responder.
// Holds the initiator request bundle, bus widths and the stall LFSR step.
package axi2mem_tcdm_pkg;

  localparam int unsigned TCDM_DW  = 32;
  localparam int unsigned TCDM_AW  = 32;
  localparam int unsigned TCDM_BEW = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [TCDM_AW-1:0]  add;
    logic                we;
    logic [TCDM_DW-1:0]  wdata;
    logic [TCDM_BEW-1:0] be;
  } tcdm_req_t;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi2mem_tcdm_rr_arb.sv
// Per-bank round-robin arbiter: one-hot grant, pointer holds the last winner.
// A stalled or resetting cycle grants nothing and leaves the pointer alone.
module axi2mem_tcdm_rr_arb #(
  parameter int unsigned NB_PORTS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NB_PORTS-1:0] req_i,
  input  logic                stall_i,
  output logic [NB_PORTS-1:0] gnt_o
);

  localparam int unsigned PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NB_PORTS - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= int'(NB_PORTS); i++) begin
      idx = PW'((int'(ptr_q) + i) % int'(NB_PORTS));
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = idx;
      end
    end
    if (rst_i || stall_i) begin
      gnt_o = '0;
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= PTR_RST;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi2mem_tcdm_resp.sv
// Word-interleaved TCDM memory behind the axi2mem engines: combinational grant, 1-cycle response.
// Optional random bank stalls via macro AXI2MEM_TCDM_RESP_STALL_EN.
module axi2mem_tcdm_resp
  import axi2mem_tcdm_pkg::*;
#(
  parameter int unsigned NB_PORTS   = 4,
  parameter int unsigned NB_BANKS   = 2,
  parameter int unsigned BANK_WORDS = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NB_PORTS-1:0]                 tcdm_req_i,
  input  logic [NB_PORTS-1:0][TCDM_AW-1:0]    tcdm_add_i,
  input  logic [NB_PORTS-1:0]                 tcdm_we_i,
  input  logic [NB_PORTS-1:0][TCDM_DW-1:0]    tcdm_wdata_i,
  input  logic [NB_PORTS-1:0][TCDM_BEW-1:0]   tcdm_be_i,
  output logic [NB_PORTS-1:0]                 tcdm_gnt_o,
  output logic [NB_PORTS-1:0][TCDM_DW-1:0]    tcdm_r_rdata_o,
  output logic [NB_PORTS-1:0]                 tcdm_r_valid_o
);

  localparam int unsigned LB  = $clog2(NB_BANKS);
  localparam int unsigned BSW = (LB > 0) ? LB : 1;
  localparam int unsigned RW  = $clog2(BANK_WORDS);
  localparam int unsigned RWW = (RW > 0) ? RW : 1;

  tcdm_req_t [NB_PORTS-1:0]           port_req;
  logic      [NB_PORTS-1:0][BSW-1:0]  port_bank;
  logic      [NB_PORTS-1:0][RWW-1:0]  port_row;

  logic [NB_BANKS-1:0][NB_PORTS-1:0]  bank_req, bank_gnt;
  logic [NB_BANKS-1:0]                bank_stall;
  tcdm_req_t [NB_BANKS-1:0]           win_req;
  logic      [NB_BANKS-1:0][RWW-1:0]  win_row;
  logic      [NB_BANKS-1:0]           win_valid;
  logic      [NB_BANKS-1:0][TCDM_DW-1:0] bank_rdata;

  logic [NB_PORTS-1:0]                valid_q, we_q;
  logic [NB_PORTS-1:0][TCDM_DW-1:0]   rdata_q;

  // Address bits above the row field and the byte offset are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{port_req, win_req};

  always_comb begin
    for (int p = 0; p < int'(NB_PORTS); p++) begin
      port_req[p]  = '{add: tcdm_add_i[p], we: tcdm_we_i[p],
                       wdata: tcdm_wdata_i[p], be: tcdm_be_i[p]};
      port_bank[p] = (LB > 0) ? port_req[p].add[2 +: BSW] : '0;
      port_row[p]  = port_req[p].add[2 + LB +: RWW];
    end
  end

  always_comb begin
    for (int b = 0; b < int'(NB_BANKS); b++)
      for (int p = 0; p < int'(NB_PORTS); p++)
        bank_req[b][p] = tcdm_req_i[p] && (port_bank[p] == BSW'(b));
  end

`ifdef AXI2MEM_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  for (genvar g = 0; g < NB_BANKS; g++) begin : g_stall
    assign bank_stall[g] = lfsr_q[g] & lfsr_q[g+8];
  end
`else
  assign bank_stall = '0;
`endif

  for (genvar g = 0; g < NB_BANKS; g++) begin : g_arb
    axi2mem_tcdm_rr_arb #(
      .NB_PORTS (NB_PORTS)
    ) i_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (bank_req[g]),
      .stall_i (bank_stall[g]),
      .gnt_o   (bank_gnt[g])
    );
  end

  always_comb begin
    tcdm_gnt_o = '0;
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      win_req[b]   = '0;
      win_row[b]   = '0;
      win_valid[b] = 1'b0;
      for (int p = 0; p < int'(NB_PORTS); p++) begin
        tcdm_gnt_o[p] = tcdm_gnt_o[p] | bank_gnt[b][p];
        if (bank_gnt[b][p]) begin
          win_req[b]   = port_req[p];
          win_row[b]   = port_row[p];
          win_valid[b] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NB_BANKS; g++) begin : g_bank
    logic [TCDM_DW-1:0] mem [BANK_WORDS];
    logic [TCDM_DW-1:0] wmask;

    assign wmask = {{8{win_req[g].be[3]}}, {8{win_req[g].be[2]}},
                    {8{win_req[g].be[1]}}, {8{win_req[g].be[0]}}};

    always_ff @(posedge clk_i) begin
      if (win_valid[g] && win_req[g].we)
        mem[win_row[g]] <= (mem[win_row[g]] & ~wmask) | (win_req[g].wdata & wmask);
    end

    assign bank_rdata[g] = mem[win_row[g]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      we_q    <= '0;
      rdata_q <= '0;
    end else begin
      valid_q <= tcdm_gnt_o;
      for (int p = 0; p < int'(NB_PORTS); p++) begin
        if (tcdm_gnt_o[p]) begin
          we_q[p] <= tcdm_we_i[p];
          if (!tcdm_we_i[p]) rdata_q[p] <= bank_rdata[port_bank[p]];
        end
      end
    end
  end

  // A response registered just before reset is suppressed while reset is asserted.
  always_comb begin
    tcdm_r_valid_o = rst_i ? '0 : valid_q;
    for (int p = 0; p < int'(NB_PORTS); p++)
      tcdm_r_rdata_o[p] = (rst_i || we_q[p]) ? '0 : rdata_q[p];
  end

endmodule
